// File: rtl/idct8_row_sched.sv
// ============================================================================
// Module   : idct8_row_sched
// Purpose  : Row sequencer for eight 8-stage IDCT systolic MAC chains. It skews
//            the row coefficients onto the chain lanes and tags chain outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module idct8_row_sched #(
    parameter int DW     = 25,
    parameter int SHIFT1 = 7,
    parameter int ADD1   = 64,
    parameter int SHIFT2 = 12,
    parameter int ADD2   = 2048
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*DW-1:0] in_data,
    input  logic            in_pass,
    output logic [8*DW-1:0] lane_data,
    output logic [3:0]      shift,
    output logic [DW-1:0]   add,
    output logic            out_valid,
    output logic            out_pass,
    output logic [2:0]      out_row,
    output logic            out_last,
    output logic            busy
);

    localparam logic [3:0]    C_SHIFT1 = 4'(SHIFT1);
    localparam logic [3:0]    C_SHIFT2 = 4'(SHIFT2);
    localparam logic [DW-1:0] C_ADD1   = DW'(ADD1);
    localparam logic [DW-1:0] C_ADD2   = DW'(ADD2);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_row_cnt;
    logic       r_blk_pass;

    logic [7:0] r_tag_v;
    logic [7:0] r_tag_p;
    logic [2:0] r_tag_row [0:7];

    logic w_acc;
    logic w_tag_pass;

    // No stall exists downstream, so the block is always ready outside reset.
    assign in_ready   = ~reset;
    assign w_acc      = in_valid & in_ready;
    assign w_tag_pass = (r_state == IDLE) ? in_pass : r_blk_pass;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_row_cnt  <= 3'd0;
            r_blk_pass <= 1'b0;
        end else if (w_acc) begin
            r_row_cnt <= r_row_cnt + 3'd1;
            if (r_state == IDLE) begin
                r_blk_pass <= in_pass;
                r_state    <= ACTIVE;
            end else if (r_row_cnt == 3'd7) begin
                r_state <= IDLE;
            end
        end
    end

    // Tag stage i is visible in cycle a+1+i; stage 7 lines up with lane 7.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_v <= 8'd0;
            r_tag_p <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                r_tag_row[i] <= 3'd0;
            end
        end else begin
            r_tag_v      <= {r_tag_v[6:0], w_acc};
            r_tag_p      <= {r_tag_p[6:0], w_tag_pass};
            r_tag_row[0] <= r_row_cnt;
            for (int i = 1; i < 8; i++) begin
                r_tag_row[i] <= r_tag_row[i-1];
            end
        end
    end

    // shift/add are loaded from stage 6 so they are valid while stage 7 is.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift     <= C_SHIFT1;
            add       <= C_ADD1;
            out_valid <= 1'b0;
            out_pass  <= 1'b0;
            out_row   <= 3'd0;
            out_last  <= 1'b0;
        end else begin
            if (r_tag_v[6]) begin
                shift <= r_tag_p[6] ? C_SHIFT2 : C_SHIFT1;
                add   <= r_tag_p[6] ? C_ADD2   : C_ADD1;
            end
            out_valid <= r_tag_v[7];
            out_pass  <= r_tag_p[7];
            out_row   <= r_tag_row[7];
            out_last  <= r_tag_v[7] & (r_tag_row[7] == 3'd7);
        end
    end

    assign busy = (r_state == ACTIVE) | (|r_tag_v) | out_valid;

    // Lane k is a k+1 deep delay line; bubbles shift in zeros.
    for (genvar k = 0; k < 8; k++) begin : g_lane
        logic [DW-1:0] r_dly [0:k];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i <= k; i++) begin
                    r_dly[i] <= '0;
                end
            end else begin
                r_dly[0] <= w_acc ? in_data[k*DW +: DW] : '0;
                for (int i = 1; i <= k; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end
        end

        assign lane_data[k*DW +: DW] = r_dly[k];
    end

endmodule

`default_nettype wire

// File: tb/tb_idct8_row_sched.sv
// ============================================================================
// Module   : tb_idct8_row_sched
// Purpose  : Directed self-checking bench for idct8_row_sched.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_idct8_row_sched;

    localparam int DW = 25;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [8*DW-1:0] in_data;
    logic            in_pass;
    logic [8*DW-1:0] lane_data;
    logic [3:0]      shift;
    logic [DW-1:0]   add;
    logic            out_valid;
    logic            out_pass;
    logic [2:0]      out_row;
    logic            out_last;
    logic            busy;

    idct8_row_sched #(
        .DW(DW), .SHIFT1(7), .ADD1(64), .SHIFT2(12), .ADD2(2048)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_pass(in_pass), .lane_data(lane_data),
        .shift(shift), .add(add), .out_valid(out_valid), .out_pass(out_pass),
        .out_row(out_row), .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int t        = 0;

    // Accept log indexed by cycle; row/pass tags are supplied by hand per step.
    logic          hv    [0:1023];
    logic [DW-1:0] hd    [0:1023][0:7];
    logic [2:0]    hrow  [0:1023];
    logic          hpass [0:1023];
    logic          exp_active;
    logic [3:0]    exp_shift;
    logic [DW-1:0] exp_add;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp_v);
        end
    endtask

    task automatic check_cycle(input logic rst_i);
        logic [DW-1:0] e;
        logic          eb;
        if (t >= 8 && hv[t-8]) begin
            exp_shift = hpass[t-8] ? 4'd12 : 4'd7;
            exp_add   = hpass[t-8] ? DW'(2048) : DW'(64);
        end
        chk("in_ready", DW'(in_ready), DW'(!rst_i));
        chk("shift", DW'(shift), DW'(exp_shift));
        chk("add", add, exp_add);
        for (int k = 0; k < 8; k++) begin
            e = (t - 1 - k >= 0 && hv[t-1-k]) ? hd[t-1-k][k] : '0;
            chk($sformatf("lane%0d", k), lane_data[k*DW +: DW], e);
        end
        eb = (t >= 9) && hv[t-9];
        chk("out_valid", DW'(out_valid), DW'(eb));
        chk("out_last", DW'(out_last), DW'(eb && hrow[t-9] == 3'd7));
        if (eb) begin
            chk("out_row", DW'(out_row), DW'(hrow[t-9]));
            chk("out_pass", DW'(out_pass), DW'(hpass[t-9]));
        end
        eb = exp_active;
        for (int i = 1; i <= 9; i++) begin
            if (t - i >= 0 && hv[t-i]) eb = 1'b1;
        end
        chk("busy", DW'(busy), DW'(eb));
    endtask

    // One cycle: drive inputs, check outputs of this cycle, log, advance.
    task automatic step(input logic rst_i, input logic v, input logic ip,
                        input int base, input int erow, input logic epass);
        reset    = rst_i;
        in_valid = v;
        in_pass  = ip;
        for (int k = 0; k < 8; k++) begin
            in_data[k*DW +: DW] = DW'(base + k);
        end
        #1;
        check_cycle(rst_i);
        if (rst_i) begin
            for (int i = 0; i <= t; i++) hv[i] = 1'b0;
            exp_active = 1'b0;
            exp_shift  = 4'd7;
            exp_add    = DW'(64);
        end else begin
            hv[t] = v;
            if (v) begin
                for (int k = 0; k < 8; k++) hd[t][k] = DW'(base + k);
                hrow[t]    = 3'(erow);
                hpass[t]   = epass;
                exp_active = (erow != 7);
            end
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            hv[i] = 1'b0;
            hrow[i] = 3'd0;
            hpass[i] = 1'b0;
            for (int k = 0; k < 8; k++) hd[i][k] = '0;
        end
        exp_active = 1'b0;
        exp_shift  = 4'd7;
        exp_add    = DW'(64);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_pass  = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #1;

        // Reset cycle: reset values and in_ready low.
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

        // 1: one pass-0 block, rows back to back, lane k = r*8+k.
        for (int r = 0; r < 8; r++) step(1'b0, 1'b1, 1'b0, r*8, r, 1'b0);
        idle(12);

        // 2: gap of three cycles after row 2.
        for (int r = 0; r < 3; r++) step(1'b0, 1'b1, 1'b0, 100 + r*8, r, 1'b0);
        idle(3);
        for (int r = 3; r < 8; r++) step(1'b0, 1'b1, 1'b0, 100 + r*8, r, 1'b0);
        idle(12);

        // 3: block A pass 0 then block B pass 1 with no drain cycle.
        for (int r = 0; r < 8; r++) step(1'b0, 1'b1, 1'b0, 200 + r*8, r, 1'b0);
        for (int r = 0; r < 8; r++) step(1'b0, 1'b1, 1'b1, 300 + r*8, r, 1'b1);
        idle(12);

        // 4: in_pass toggles every beat; row 0 selects pass 1 for the block.
        for (int r = 0; r < 8; r++) step(1'b0, 1'b1, (r % 2 == 0), 400 + r*8, r, 1'b1);
        idle(12);

        // 5: reset four cycles after row 5 discards the partial block.
        for (int r = 0; r < 6; r++) step(1'b0, 1'b1, 1'b0, 500 + r*8, r, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 600, 0, 1'b1);
        for (int r = 1; r < 7; r++) step(1'b0, 1'b1, 1'b0, 600 + r*8, r, 1'b1);
        idle(12);

        // 6: single final row, then idle; busy drains and shift/add hold.
        step(1'b0, 1'b1, 1'b0, 700, 7, 1'b1);
        idle(14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
